// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0]  Rs1D, Rs2D;
  logic [REG_W-1:0]  Rs1E, Rs2E, RdE;
  logic [REG_W-1:0]  RdM, RdW;
  logic              regWriteM, regWriteW;
  logic [1:0]        resultSrcE;
  logic              PCSrcE;
  logic              memReqM, memReadyM;

  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, flushW;
  logic [1:0]        forwardAE, forwardBE;
  logic              memErr;
  logic [PERF_W-1:0] stallCycles, flushCount;

  // Pipeline side: presents register numbers and memory status.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output regWriteM, regWriteW, resultSrcE, PCSrcE, memReqM, memReadyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
    input  forwardAE, forwardBE, memErr, stallCycles, flushCount
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  regWriteM, regWriteW, resultSrcE, PCSrcE, memReqM, memReadyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
    output forwardAE, forwardBE, memErr, stallCycles, flushCount
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Execute-stage forwarding select for one operand; M stage beats W stage.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       sel
);

  // Youngest matching producer wins; x0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush sequencing, forwarding selects, memory
// wait freeze with timeout halt. Optional performance counters are built
// when HAZARD_PERF_EN is defined; otherwise the counter ports read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err;

  logic             lw_stall;
  logic             mem_stall;
  logic [1:0]       fwd_a, fwd_b;

  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;

  fwd_sel u_fwd_a (
    .rs          (bus.Rs1E),
    .rd_m        (bus.RdM),
    .rd_w        (bus.RdW),
    .reg_write_m (bus.regWriteM),
    .reg_write_w (bus.regWriteW),
    .sel         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs          (bus.Rs2E),
    .rd_m        (bus.RdM),
    .rd_w        (bus.RdW),
    .reg_write_m (bus.regWriteM),
    .reg_write_w (bus.regWriteW),
    .sel         (fwd_b)
  );

  // Load-use hazard between the load in E and a consumer in D.
  always_comb begin
    lw_stall = (bus.resultSrcE == RESULT_SRC_LOAD) && (bus.RdE != '0) &&
               ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  end

  // Freeze whenever an access is outstanding or the core is halted.
  always_comb begin
    unique case (state)
      RUN:      mem_stall = bus.memReqM && !bus.memReadyM;
      MEM_WAIT: mem_stall = !bus.memReadyM;
      HALT:     mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  // Stall/flush outputs; a freeze holds any redirect or bubble until release.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        flush_d = bus.PCSrcE;
        flush_e = bus.PCSrcE || lw_stall;
        stall_f = lw_stall && !bus.PCSrcE;
        stall_d = lw_stall && !bus.PCSrcE;
      end
    end
  end

  // Memory-wait state machine with timeout counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.memReqM && !bus.memReadyM) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.memReadyM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            state   <= HALT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_f) stall_cycles <= stall_cycles + PERF_W'(1);
      if (flush_e) flush_count  <= flush_count + PERF_W'(1);
    end
  end

  assign bus.stallCycles = stall_cycles;
  assign bus.flushCount  = flush_count;
`else
  assign bus.stallCycles = '0;
  assign bus.flushCount  = '0;
`endif

  assign bus.stallF    = stall_f;
  assign bus.stallD    = stall_d;
  assign bus.stallE    = stall_e;
  assign bus.stallM    = stall_m;
  assign bus.flushD    = flush_d;
  assign bus.flushE    = flush_e;
  assign bus.flushW    = flush_w;
  assign bus.forwardAE = rst ? FWD_RF : fwd_a;
  assign bus.forwardBE = rst ? FWD_RF : fwd_b;
  assign bus.memErr    = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int    tests  = 0;
  int    failed = 0;
  string step   = "init";

  // Model state: mode 0 = running, 1 = waiting on memory, 2 = halted.
  int          m_mode;
  int          m_waits;
  bit          m_err;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  // Expected combinational outputs.
  bit         e_stall, e_sf, e_fd, e_fe, e_fw;
  logic [1:0] e_fa, e_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (bus.regWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.regWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_waits = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_outputs();
    bit frozen, lw;
    e_stall = 0; e_sf = 0; e_fd = 0; e_fe = 0; e_fw = 0; e_fa = 0; e_fb = 0;
    if (!rst) begin
      lw = (bus.resultSrcE == 2'b01) && bus.RdE != 0 &&
           (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
      frozen = (m_mode == 2) || (!bus.memReadyM && (m_mode == 1 || bus.memReqM));
      e_fa = fwd_ref(bus.Rs1E);
      e_fb = fwd_ref(bus.Rs2E);
      if (frozen) begin
        e_stall = 1; e_sf = 1; e_fw = 1;
      end else begin
        e_fd = bus.PCSrcE;
        e_fe = bus.PCSrcE | lw;
        e_sf = lw & ~bus.PCSrcE;
      end
    end
  endtask

  task automatic check_outputs();
    model_outputs();
    chk("stallF", 32'(bus.stallF), 32'(e_sf));
    chk("stallD", 32'(bus.stallD), 32'(e_sf));
    chk("stallE", 32'(bus.stallE), 32'(e_stall));
    chk("stallM", 32'(bus.stallM), 32'(e_stall));
    chk("flushD", 32'(bus.flushD), 32'(e_fd));
    chk("flushE", 32'(bus.flushE), 32'(e_fe));
    chk("flushW", 32'(bus.flushW), 32'(e_fw));
    chk("forwardAE", 32'(bus.forwardAE), 32'(e_fa));
    chk("forwardBE", 32'(bus.forwardBE), 32'(e_fb));
    chk("memErr", 32'(bus.memErr), 32'(m_err));
`ifdef HAZARD_PERF_EN
    chk("stallCycles", bus.stallCycles, m_stalls);
    chk("flushCount", bus.flushCount, m_flushes);
`else
    chk("stallCycles", bus.stallCycles, 32'd0);
    chk("flushCount", bus.flushCount, 32'd0);
`endif
  endtask

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (e_sf) m_stalls++;
    if (e_fe) m_flushes++;
    case (m_mode)
      0: if (bus.memReqM && !bus.memReadyM) begin m_mode = 1; m_waits = 1; end
      1: begin
        if (bus.memReadyM) m_mode = 0;
        else if (m_waits == TO) begin m_mode = 2; m_err = 1; end
        else m_waits++;
      end
      default: ;
    endcase
  endtask

  // Check this cycle's outputs, take the edge, return at the next negedge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0; bus.RdE = 0;
    bus.RdM = 0; bus.RdW = 0; bus.regWriteM = 0; bus.regWriteW = 0;
    bus.resultSrcE = 0; bus.PCSrcE = 0; bus.memReqM = 0; bus.memReadyM = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    step = "reset";
    check_outputs();
    @(negedge clk);
    tick();
    rst = 1'b0;

    step = "fwd_m_over_w";
    bus.Rs1E = 5; bus.RdM = 5; bus.regWriteM = 1; bus.RdW = 5; bus.regWriteW = 1;
    #1 chk("fwdA_explicit", 32'(bus.forwardAE), 32'(2'b10));
    tick();
    step = "fwd_w_rd_m_zero";
    bus.RdM = 0;
    #1 chk("fwdA_explicit", 32'(bus.forwardAE), 32'(2'b01));
    tick();

    step = "load_use";
    idle_inputs();
    bus.resultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7; bus.memReadyM = 1;
    #1 chk("stallF_explicit", 32'(bus.stallF), 32'd1);
    tick();
    bus.resultSrcE = 2'b00;
    #1 chk("stallF_after", 32'(bus.stallF), 32'd0);
    tick();
    step = "load_use_redirect";
    bus.resultSrcE = 2'b01; bus.PCSrcE = 1;
    #1 chk("stallF_explicit", 32'(bus.stallF), 32'd0);
    chk("flushD_explicit", 32'(bus.flushD), 32'd1);
    tick();

    step = "mem_wait3";
    idle_inputs();
    bus.memReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stallE_explicit", 32'(bus.stallE), 32'd1);
      tick();
    end
    bus.memReadyM = 1;
    #1 chk("release_stallE", 32'(bus.stallE), 32'd0);
    tick();
    bus.memReqM = 0;
    tick();

    step = "timeout";
    bus.memReqM = 1; bus.memReadyM = 0;
    for (int i = 0; i < int'(TO) + 1; i++) tick();
    bus.memReqM = 0;
    #1 chk("memErr_explicit", 32'(bus.memErr), 32'd1);
    chk("halt_stallM", 32'(bus.stallM), 32'd1);
    tick();
    tick();
    step = "async_reset";
    rst = 1'b1;
    model_reset();
    #1 chk("memErr_async", 32'(bus.memErr), 32'd0);
    check_outputs();
    tick();
    rst = 1'b0;
    tick();

    step = "ready_at_limit";
    bus.memReqM = 1; bus.memReadyM = 0;
    for (int i = 0; i < int'(TO); i++) tick();
    bus.memReadyM = 1;
    tick();
    bus.memReqM = 0;
    #1 chk("memErr_stays0", 32'(bus.memErr), 32'd0);
    tick();

    step = "redirect_in_wait";
    bus.memReqM = 1; bus.memReadyM = 0;
    tick();
    bus.PCSrcE = 1;
    #1 chk("flushD_held", 32'(bus.flushD), 32'd0);
    tick();
    bus.memReadyM = 1;
    #1 chk("flushE_release", 32'(bus.flushE), 32'd1);
    tick();
    idle_inputs();
    tick();

    step = "random";
    for (int n = 0; n < 600; n++) begin
      bus.Rs1D = 5'($urandom_range(0, 7)); bus.Rs2D = 5'($urandom_range(0, 7));
      bus.Rs1E = 5'($urandom_range(0, 7)); bus.Rs2E = 5'($urandom_range(0, 7));
      bus.RdE  = 5'($urandom_range(0, 7)); bus.RdM  = 5'($urandom_range(0, 7));
      bus.RdW  = 5'($urandom_range(0, 7));
      bus.regWriteM = 1'($urandom); bus.regWriteW = 1'($urandom);
      bus.resultSrcE = 2'($urandom); bus.PCSrcE = ($urandom_range(0, 3) == 0);
      bus.memReqM = ($urandom_range(0, 2) == 0);
      bus.memReadyM = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 40) == 0);
      if (rst) model_reset();
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
